// File: rtl/axi_demux_ordered_err.sv
// AXI4 1-to-N demultiplexer. Responses stay in order because each direction talks to a single target at a time.
// Selects at or above NoMstPorts are answered with DECERR by an internal error slave.
module axi_demux_ordered_err #(
  parameter int NoMstPorts = 4,
  parameter int IdWidth    = 4,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int MaxTrans   = 8,
  parameter int WFifoDepth = 4,
  parameter int SelWidth   = $clog2(NoMstPorts + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 slv_aw_valid_i,
  input  logic [IdWidth-1:0]                   slv_aw_id_i,
  input  logic [AddrWidth-1:0]                 slv_aw_addr_i,
  input  logic [7:0]                           slv_aw_len_i,
  input  logic [SelWidth-1:0]                  slv_aw_sel_i,
  output logic                                 slv_aw_ready_o,
  input  logic                                 slv_w_valid_i,
  input  logic [DataWidth-1:0]                 slv_w_data_i,
  input  logic                                 slv_w_last_i,
  output logic                                 slv_w_ready_o,
  output logic                                 slv_b_valid_o,
  output logic [IdWidth-1:0]                   slv_b_id_o,
  output logic [1:0]                           slv_b_resp_o,
  input  logic                                 slv_b_ready_i,
  input  logic                                 slv_ar_valid_i,
  input  logic [IdWidth-1:0]                   slv_ar_id_i,
  input  logic [AddrWidth-1:0]                 slv_ar_addr_i,
  input  logic [7:0]                           slv_ar_len_i,
  input  logic [SelWidth-1:0]                  slv_ar_sel_i,
  output logic                                 slv_ar_ready_o,
  output logic                                 slv_r_valid_o,
  output logic [IdWidth-1:0]                   slv_r_id_o,
  output logic [DataWidth-1:0]                 slv_r_data_o,
  output logic [1:0]                           slv_r_resp_o,
  output logic                                 slv_r_last_o,
  input  logic                                 slv_r_ready_i,
  output logic [NoMstPorts-1:0]                mst_aw_valid_o,
  output logic [NoMstPorts-1:0][IdWidth-1:0]   mst_aw_id_o,
  output logic [NoMstPorts-1:0][AddrWidth-1:0] mst_aw_addr_o,
  output logic [NoMstPorts-1:0][7:0]           mst_aw_len_o,
  input  logic [NoMstPorts-1:0]                mst_aw_ready_i,
  output logic [NoMstPorts-1:0]                mst_w_valid_o,
  output logic [NoMstPorts-1:0][DataWidth-1:0] mst_w_data_o,
  output logic [NoMstPorts-1:0]                mst_w_last_o,
  input  logic [NoMstPorts-1:0]                mst_w_ready_i,
  input  logic [NoMstPorts-1:0]                mst_b_valid_i,
  input  logic [NoMstPorts-1:0][IdWidth-1:0]   mst_b_id_i,
  input  logic [NoMstPorts-1:0][1:0]           mst_b_resp_i,
  output logic [NoMstPorts-1:0]                mst_b_ready_o,
  output logic [NoMstPorts-1:0]                mst_ar_valid_o,
  output logic [NoMstPorts-1:0][IdWidth-1:0]   mst_ar_id_o,
  output logic [NoMstPorts-1:0][AddrWidth-1:0] mst_ar_addr_o,
  output logic [NoMstPorts-1:0][7:0]           mst_ar_len_o,
  input  logic [NoMstPorts-1:0]                mst_ar_ready_i,
  input  logic [NoMstPorts-1:0]                mst_r_valid_i,
  input  logic [NoMstPorts-1:0][IdWidth-1:0]   mst_r_id_i,
  input  logic [NoMstPorts-1:0][DataWidth-1:0] mst_r_data_i,
  input  logic [NoMstPorts-1:0][1:0]           mst_r_resp_i,
  input  logic [NoMstPorts-1:0]                mst_r_last_i,
  output logic [NoMstPorts-1:0]                mst_r_ready_o
);

  localparam int CntWidth = $clog2(MaxTrans + 1);
  localparam int PtrWidth = $clog2(WFifoDepth);
  localparam logic [SelWidth-1:0] ErrIdx = SelWidth'(NoMstPorts);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [PtrWidth:0]   PtrOne = (PtrWidth + 1)'(1);

  typedef enum logic [1:0] {WR_IDLE, WR_DRAIN, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic [SelWidth-1:0] aw_sel, ar_sel, aw_cur, ar_cur, w_head;
  logic [CntWidth-1:0] aw_cnt, ar_cnt;
  logic aw_go, ar_go, aw_tgt_ready, ar_tgt_ready, w_tgt_ready;
  logic aw_hs, ar_hs, w_hs, w_pop, b_hs, r_hs;
  logic [SelWidth-1:0] route_mem [WFifoDepth];
  logic [PtrWidth:0] wr_ptr, rd_ptr;
  logic fifo_empty, fifo_full;
  logic [IdWidth-1:0] err_wid, err_rid;
  logic [7:0] err_len, err_beat;
  logic err_w_ready, err_b_valid, err_r_valid, err_r_last;

  // Every out-of-range select collapses onto one error index.
  assign aw_sel = (slv_aw_sel_i >= ErrIdx) ? ErrIdx : slv_aw_sel_i;
  assign ar_sel = (slv_ar_sel_i >= ErrIdx) ? ErrIdx : slv_ar_sel_i;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]) &&
                      (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]);
  assign w_head     = route_mem[rd_ptr[PtrWidth-1:0]];

  always_comb begin
    aw_go = !rst_i && slv_aw_valid_i && !fifo_full && (aw_cnt < CntMax) &&
            (aw_cnt == '0 || aw_sel == aw_cur) && (aw_sel != ErrIdx || wr_state == WR_IDLE);
    ar_go = !rst_i && slv_ar_valid_i && (ar_cnt < CntMax) &&
            (ar_cnt == '0 || ar_sel == ar_cur) && (ar_sel != ErrIdx || rd_state == RD_IDLE);
    aw_tgt_ready = (aw_sel == ErrIdx);
    ar_tgt_ready = (ar_sel == ErrIdx);
    w_tgt_ready  = (w_head == ErrIdx) && err_w_ready;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (aw_sel == SelWidth'(i)) aw_tgt_ready = mst_aw_ready_i[i];
      if (ar_sel == SelWidth'(i)) ar_tgt_ready = mst_ar_ready_i[i];
      if (w_head == SelWidth'(i)) w_tgt_ready  = mst_w_ready_i[i];
      mst_aw_valid_o[i] = aw_go && (aw_sel == SelWidth'(i));
      mst_aw_id_o[i]    = slv_aw_id_i;
      mst_aw_addr_o[i]  = slv_aw_addr_i;
      mst_aw_len_o[i]   = slv_aw_len_i;
      mst_ar_valid_o[i] = ar_go && (ar_sel == SelWidth'(i));
      mst_ar_id_o[i]    = slv_ar_id_i;
      mst_ar_addr_o[i]  = slv_ar_addr_i;
      mst_ar_len_o[i]   = slv_ar_len_i;
      mst_w_valid_o[i]  = !rst_i && !fifo_empty && slv_w_valid_i && (w_head == SelWidth'(i));
      mst_w_data_o[i]   = slv_w_data_i;
      mst_w_last_o[i]   = slv_w_last_i;
      mst_b_ready_o[i]  = !rst_i && slv_b_ready_i && (aw_cur == SelWidth'(i));
      mst_r_ready_o[i]  = !rst_i && slv_r_ready_i && (ar_cur == SelWidth'(i));
    end
    slv_aw_ready_o = aw_go && aw_tgt_ready;
    slv_ar_ready_o = ar_go && ar_tgt_ready;
    slv_w_ready_o  = !rst_i && !fifo_empty && w_tgt_ready;
  end

  // Responses come only from the current target of each direction.
  always_comb begin
    slv_b_valid_o = 1'b0;
    slv_b_id_o    = '0;
    slv_b_resp_o  = 2'b00;
    slv_r_valid_o = 1'b0;
    slv_r_id_o    = '0;
    slv_r_data_o  = '0;
    slv_r_resp_o  = 2'b00;
    slv_r_last_o  = 1'b0;
    if (!rst_i) begin
      if (aw_cur == ErrIdx) begin
        slv_b_valid_o = err_b_valid;
        slv_b_id_o    = err_wid;
        slv_b_resp_o  = 2'b11;
      end
      if (ar_cur == ErrIdx) begin
        slv_r_valid_o = err_r_valid;
        slv_r_id_o    = err_rid;
        slv_r_resp_o  = 2'b11;
        slv_r_last_o  = err_r_last;
      end
      for (int i = 0; i < NoMstPorts; i++) begin
        if (aw_cur == SelWidth'(i)) begin
          slv_b_valid_o = mst_b_valid_i[i];
          slv_b_id_o    = mst_b_id_i[i];
          slv_b_resp_o  = mst_b_resp_i[i];
        end
        if (ar_cur == SelWidth'(i)) begin
          slv_r_valid_o = mst_r_valid_i[i];
          slv_r_id_o    = mst_r_id_i[i];
          slv_r_data_o  = mst_r_data_i[i];
          slv_r_resp_o  = mst_r_resp_i[i];
          slv_r_last_o  = mst_r_last_i[i];
        end
      end
    end
  end

  assign aw_hs = slv_aw_valid_i && slv_aw_ready_o;
  assign ar_hs = slv_ar_valid_i && slv_ar_ready_o;
  assign w_hs  = slv_w_valid_i && slv_w_ready_o;
  assign w_pop = w_hs && slv_w_last_i;
  assign b_hs  = slv_b_valid_o && slv_b_ready_i;
  assign r_hs  = slv_r_valid_o && slv_r_ready_i;

  always_ff @(posedge clk_i) begin
    if (aw_hs) route_mem[wr_ptr[PtrWidth-1:0]] <= aw_sel;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      aw_cnt <= '0;
      ar_cnt <= '0;
      aw_cur <= '0;
      ar_cur <= '0;
    end else begin
      if (aw_hs) wr_ptr <= wr_ptr + PtrOne;
      if (w_pop) rd_ptr <= rd_ptr + PtrOne;
      if (aw_hs) aw_cur <= aw_sel;
      if (ar_hs) ar_cur <= ar_sel;
      if (aw_hs && !b_hs) aw_cnt <= aw_cnt + CntOne;
      else if (!aw_hs && b_hs) aw_cnt <= aw_cnt - CntOne;
      if (ar_hs && !(r_hs && slv_r_last_o)) ar_cnt <= ar_cnt + CntOne;
      else if (!ar_hs && r_hs && slv_r_last_o) ar_cnt <= ar_cnt - CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    unique case (wr_state)
      WR_IDLE:  if (aw_hs && aw_sel == ErrIdx) wr_next = WR_DRAIN;
      WR_DRAIN: if (w_pop && w_head == ErrIdx) wr_next = WR_RESP;
      WR_RESP:  if (b_hs) wr_next = WR_IDLE;
      default:  wr_next = WR_IDLE;
    endcase
    unique case (rd_state)
      RD_IDLE:  if (ar_hs && ar_sel == ErrIdx) rd_next = RD_BURST;
      RD_BURST: if (r_hs && err_r_last) rd_next = RD_IDLE;
      default:  rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    err_w_ready = (wr_state == WR_DRAIN);
    err_b_valid = (wr_state == WR_RESP);
    err_r_valid = (rd_state == RD_BURST);
    err_r_last  = (err_beat == err_len);
  end

  // An 8-bit beat counter compared against len gives exactly len+1 beats, up to 256.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_wid  <= '0;
      err_rid  <= '0;
      err_len  <= '0;
      err_beat <= '0;
    end else begin
      if (aw_hs && aw_sel == ErrIdx) err_wid <= slv_aw_id_i;
      if (ar_hs && ar_sel == ErrIdx) begin
        err_rid  <= slv_ar_id_i;
        err_len  <= slv_ar_len_i;
        err_beat <= '0;
      end else if (r_hs && rd_state == RD_BURST) begin
        err_beat <= err_beat + 8'd1;
      end
    end
  end

endmodule
